// File: rtl/vga_fb_arbiter.sv
// Frame buffer port arbiter: VGA reads always win, queued PPU writes
// drain in free cycles. Ports: clock/reset, read req/resp, write
// valid/ready, registered RAM port, FIFO level, drop and starve flags.
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 6,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned FB_WORDS     = 61440,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                              vga_clock,
  input  logic                              rst_n,
  input  logic                              rd_req,
  input  logic [ADDR_W-1:0]                 rd_addr,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              rd_valid,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [DATA_W-1:0]                 wr_data,
  output logic [ADDR_W-1:0]                 ram_addr,
  output logic [DATA_W-1:0]                 ram_wdata,
  output logic                              ram_we,
  input  logic [DATA_W-1:0]                 ram_q,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              wr_drop,
  output logic                              starve,
  input  logic                              clear_starve
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [LVL_W-1:0]  FULL   = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  LIM    = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W:0]   FB_END = (ADDR_W + 1)'(FB_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE
  } state_e;

  state_e state_q, state_d;

  // Write FIFO storage and bookkeeping
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_oor;
  logic              rd_oor;

  // RAM port registers
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              wr_drop_q, wr_drop_d;

  // Read return pipeline: stage 1 is the READ grant, stage 2 waits
  // for the RAM, then the result is captured.
  logic              oor1_q;
  logic              rd2_q, oor2_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q;

  // Starvation tracking
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              starve_q, starve_d;

  assign fifo_empty = (level_q == '0);
  assign wr_ready   = (level_q != FULL);
  assign push       = wr_valid && wr_ready;
  assign head_addr  = fifo_addr_q[rptr_q];
  assign head_data  = fifo_data_q[rptr_q];
  assign head_oor   = ({1'b0, head_addr} >= FB_END);
  assign rd_oor     = ({1'b0, rd_addr} >= FB_END);

  // Grant: reads first, then FIFO head, else idle
  always_comb begin
    state_d     = S_IDLE;
    pop         = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    wr_drop_d   = 1'b0;
    if (rd_req) begin
      state_d    = S_READ;
      ram_addr_d = rd_addr;
    end else if (!fifo_empty) begin
      state_d     = S_WRITE;
      pop         = 1'b1;
      ram_addr_d  = head_addr;
      ram_wdata_d = head_data;
      ram_we_d    = !head_oor;
      wr_drop_d   = head_oor;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    if (push) begin
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pop || fifo_empty) begin
      cnt_d = '0;
    end else if (rd_req && (cnt_q != LIM)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Set only on the edge the limit is reached, so it beats a
    // coincident clear but a later clear sticks.
    starve_d = starve_q;
    if ((cnt_q != LIM) && (cnt_d == LIM)) begin
      starve_d = 1'b1;
    end else if (clear_starve) begin
      starve_d = 1'b0;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd2_q) begin
      rd_data_d = oor2_q ? '0 : ram_q;
    end
  end

  always_ff @(posedge vga_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      wr_drop_q   <= 1'b0;
      oor1_q      <= 1'b0;
      rd2_q       <= 1'b0;
      oor2_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      cnt_q       <= '0;
      starve_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      wr_drop_q   <= wr_drop_d;
      oor1_q      <= rd_req && rd_oor;
      rd2_q       <= (state_q == S_READ);
      oor2_q      <= oor1_q;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd2_q;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge vga_clock) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= wr_addr;
      fifo_data_q[wptr_q] <= wr_data;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_we     = ram_we_q;
  assign fifo_level = level_q;
  assign wr_drop    = wr_drop_q;
  assign starve     = starve_q;

endmodule
